// File: rtl/wr_data_queue_if.sv
// AXI-Stream style bus bundle used for both the user write-data input and
// the drained output toward the host DMA path.
interface wr_data_queue_if #(
  parameter int DATA_BITS = 512
);
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/wr_data_queue.sv
// wr_data_queue: write-data staging buffer ahead of the write credit stage.
// User beats land in a first-word-fall-through data FIFO (xfer pulses once per
// stored beat); granted request lengths land in a length FIFO as beat counts.
// A two-state drain FSM pairs each length with its beats and regenerates tlast
// at every request boundary. Zero-beat lengths are consumed silently.
// Optional macro WR_QUEUE_STATS_EN enables the stat_beats_in / stat_reqs_done
// counters; without it both outputs are tied to zero.
module wr_data_queue #(
  parameter int DATA_BITS = 512,
  parameter int QDEPTH    = 64,
  parameter int LEN_BITS  = 28,
  parameter int LDEPTH    = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  wr_data_queue_if.slave      s_axis,
  output logic                xfer,
  input  logic [LEN_BITS-1:0] s_len_data,
  input  logic                s_len_valid,
  output logic                s_len_ready,
  wr_data_queue_if.master     m_axis,
  output logic [31:0]         stat_beats_in,
  output logic [31:0]         stat_reqs_done
);

  localparam int KEEP_BITS     = DATA_BITS / 8;
  localparam int BEAT_LOG_BITS = $clog2(KEEP_BITS);
  localparam int BLEN_BITS     = LEN_BITS - BEAT_LOG_BITS;
  localparam int NB_W          = BLEN_BITS + 1;
  localparam int BEAT_W        = DATA_BITS + KEEP_BITS;
  localparam int QPTR_W        = $clog2(QDEPTH);
  localparam int QCNT_W        = QPTR_W + 1;
  localparam int LPTR_W        = $clog2(LDEPTH);
  localparam int LCNT_W        = LPTR_W + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Data FIFO state
  logic [BEAT_W-1:0] r_dmem [QDEPTH];
  logic [QPTR_W-1:0] r_dwptr;
  logic [QPTR_W-1:0] r_drptr;
  logic [QCNT_W-1:0] r_dcnt;
  logic [QCNT_W-1:0] w_dcnt_nxt;
  logic              r_dfull;
  logic              w_dempty;
  logic              w_dpush;
  logic              w_dpop;
  logic [BEAT_W-1:0] w_dhead;

  // Length FIFO state
  logic [NB_W-1:0]   r_lmem [LDEPTH];
  logic [LPTR_W-1:0] r_lwptr;
  logic [LPTR_W-1:0] r_lrptr;
  logic [LCNT_W-1:0] r_lcnt;
  logic [LCNT_W-1:0] w_lcnt_nxt;
  logic              r_lfull;
  logic              w_lempty;
  logic              w_lpush;
  logic              w_lpop;
  logic [NB_W-1:0]   w_lhead;
  logic [NB_W-1:0]   w_len_beats;

  // Drain FSM state
  state_t            r_state;
  state_t            w_state_nxt;
  logic [NB_W-1:0]   r_cnt;
  logic [NB_W-1:0]   w_cnt_nxt;
  logic              w_mvalid;
  logic              w_mlast;
  logic              w_req_done;

  // Input tlast and the sub-beat byte remainder of a length carry no meaning here.
  logic w_unused_inputs;
  assign w_unused_inputs = ^{s_axis.tlast, s_len_data[BEAT_LOG_BITS-1:0]};

  assign w_dempty      = (r_dcnt == '0);
  assign w_dpush       = s_axis.tvalid & ~r_dfull;
  assign w_dhead       = r_dmem[r_drptr];
  assign s_axis.tready = ~r_dfull;
  assign xfer          = w_dpush;

  assign w_lempty    = (r_lcnt == '0);
  assign w_lpush     = s_len_valid & ~r_lfull;
  assign w_lhead     = r_lmem[r_lrptr];
  assign s_len_ready = ~r_lfull;
  assign w_len_beats = {1'b0, s_len_data[LEN_BITS-1:BEAT_LOG_BITS]};

  assign w_dpop = w_mvalid & m_axis.tready;

  assign m_axis.tvalid = w_mvalid;
  assign m_axis.tlast  = w_mlast;
  assign m_axis.tdata  = w_dhead[DATA_BITS-1:0];
  assign m_axis.tkeep  = w_dhead[BEAT_W-1:DATA_BITS];

  // Next data occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_dcnt_nxt = r_dcnt;
    if (w_dpush && !w_dpop)      w_dcnt_nxt = r_dcnt + QCNT_W'(1);
    else if (!w_dpush && w_dpop) w_dcnt_nxt = r_dcnt - QCNT_W'(1);
  end

  // Data FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_dwptr <= '0;
      r_drptr <= '0;
      r_dcnt  <= '0;
      r_dfull <= 1'b0;
    end else begin
      if (w_dpush) r_dwptr <= r_dwptr + QPTR_W'(1);
      if (w_dpop)  r_drptr <= r_drptr + QPTR_W'(1);
      r_dcnt  <= w_dcnt_nxt;
      r_dfull <= (w_dcnt_nxt == QCNT_W'(QDEPTH));
    end
  end

  // Data FIFO storage: beat and byte enables written together, no reset needed.
  always_ff @(posedge aclk) begin
    if (w_dpush) r_dmem[r_dwptr] <= {s_axis.tkeep, s_axis.tdata};
  end

  // Next length occupancy.
  always_comb begin
    w_lcnt_nxt = r_lcnt;
    if (w_lpush && !w_lpop)      w_lcnt_nxt = r_lcnt + LCNT_W'(1);
    else if (!w_lpush && w_lpop) w_lcnt_nxt = r_lcnt - LCNT_W'(1);
  end

  // Length FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_lwptr <= '0;
      r_lrptr <= '0;
      r_lcnt  <= '0;
      r_lfull <= 1'b0;
    end else begin
      if (w_lpush) r_lwptr <= r_lwptr + LPTR_W'(1);
      if (w_lpop)  r_lrptr <= r_lrptr + LPTR_W'(1);
      r_lcnt  <= w_lcnt_nxt;
      r_lfull <= (w_lcnt_nxt == LCNT_W'(LDEPTH));
    end
  end

  // Length FIFO storage holds beat counts, converted from bytes on entry.
  always_ff @(posedge aclk) begin
    if (w_lpush) r_lmem[r_lwptr] <= w_len_beats;
  end

  // Drain FSM state register and remaining-beat counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Drain FSM next state and outputs: IDLE pops lengths, ACTIVE streams beats.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mvalid    = 1'b0;
    w_mlast     = 1'b0;
    w_req_done  = 1'b0;
    w_lpop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_lempty) begin
          w_lpop = 1'b1;
          if (w_lhead != '0) begin
            w_cnt_nxt   = w_lhead - NB_W'(1);
            w_state_nxt = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        w_mvalid = ~w_dempty;
        w_mlast  = (r_cnt == '0);
        if (w_mvalid && m_axis.tready) begin
          if (r_cnt == '0) begin
            w_req_done  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - NB_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef WR_QUEUE_STATS_EN
  logic [31:0] r_stat_beats;
  logic [31:0] r_stat_reqs;

  // Statistics: accepted beats and completed requests, wrapping at 2**32.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_stat_beats <= '0;
      r_stat_reqs  <= '0;
    end else begin
      if (xfer)       r_stat_beats <= r_stat_beats + 32'd1;
      if (w_req_done) r_stat_reqs  <= r_stat_reqs + 32'd1;
    end
  end

  assign stat_beats_in  = r_stat_beats;
  assign stat_reqs_done = r_stat_reqs;
`else
  logic w_unused_req_done;
  assign w_unused_req_done = w_req_done;
  assign stat_beats_in     = 32'd0;
  assign stat_reqs_done    = 32'd0;
`endif

endmodule

// File: doc/wr_data_queue.md
Name: wr_data_queue

Overview:
- Write-data staging buffer that sits directly upstream of the write credit stage.
- Accepts user write data on AXI-Stream and stores it in a FIFO. Pulses xfer once per beat stored; this feeds the credit stage's beat counter.
- Accepts the lengths of requests already granted downstream and drains the stored data to the host DMA path. tlast is regenerated at each request boundary.

Parameters:
- DATA_BITS, 512, data bus width; BEAT_LOG_BITS = log2(DATA_BITS/8), derived internally.
- QDEPTH, 64, data FIFO depth in beats; power of 2, >= 4, <= 2**BLEN_BITS.
- LEN_BITS, 28, request length field width (bytes).
- LDEPTH, 8, length FIFO depth in entries; power of 2, >= 2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  DATA_BITS  user write data
- s_axis_tkeep  in  DATA_BITS/8  byte enables
- s_axis_tlast  in  1  ignored; boundaries come from s_len
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  data FIFO not full
- xfer  out  1  one-cycle pulse per accepted input beat
- s_len_data  in  LEN_BITS  byte length of a granted write request
- s_len_valid  in  1  length valid
- s_len_ready  out  1  length FIFO not full
- m_axis_tdata  out  DATA_BITS  drained data
- m_axis_tkeep  out  DATA_BITS/8  drained byte enables
- m_axis_tlast  out  1  last beat of current request
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- stat_beats_in  out  32  beats accepted (see Optional Feature)
- stat_reqs_done  out  32  requests completed (see Optional Feature)

Behaviour:
- Reset: clock aclk; reset aresetn, synchronous, active-low. On reset, both FIFOs are emptied, FSM goes to IDLE, beat counter = 0, stats = 0.
- Output values during and immediately after reset:
  - s_axis_tready = 1, s_len_ready = 1.
  - xfer = 0, m_axis_tvalid = 0, m_axis_tlast = 0.
  - m_axis_tdata and m_axis_tkeep are don't-care.
- Reset mid-request discards all stored data and lengths. No partial tlast is emitted.
- Data FIFO:
  - First-word-fall-through.
  - Push on s_axis_tvalid & s_axis_tready.
  - s_axis_tready = !data_full, registered full flag. No push-through when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when neither full nor empty leaves the occupancy unchanged.
- xfer = s_axis_tvalid & s_axis_tready, combinational, same cycle as the push. Exactly one pulse per beat; never asserted while full.
- Length FIFO:
  - First-word-fall-through.
  - Push on s_len_valid & s_len_ready; s_len_ready = !len_full.
  - n_beats = s_len_data >> BEAT_LOG_BITS, computed at push and stored as BLEN_BITS+1 bits. Lengths are byte multiples of DATA_BITS/8; the remainder is truncated.
- FSM IDLE:
  - If the length FIFO is non-empty and its head n_beats == 0, pop it and stay in IDLE; no data is emitted.
  - If n_beats > 0, load cnt = n_beats-1, pop the length FIFO, go to ACTIVE.
  - IDLE to ACTIVE costs one cycle.
- FSM ACTIVE:
  - m_axis_tvalid = !data_empty; data and keep are taken from the FIFO head.
  - m_axis_tlast = (cnt == 0).
  - On handshake: if cnt == 0, increment stat_reqs_done and go to IDLE; otherwise decrement cnt.
  - tvalid, once high, holds until handshake; data is stable while tvalid & !tready.
- m_axis_tvalid is always 0 in IDLE.
- Data may arrive before or after its length. Output stalls on whichever is missing.
- Width rules:
  - Occupancy counters are log2(QDEPTH)+1 bits; pointers wrap modulo depth.
  - Stats wrap modulo 2**32.

Optional Feature:
- Macro: WR_QUEUE_STATS_EN.
- Defined: stat_beats_in increments on every xfer; stat_reqs_done increments on every tlast handshake. Both are 32-bit registers, cleared on reset.
- Not defined: both stat outputs are tied to 0 and no counter logic is synthesised. Ports remain present.

Test Plan:
- Reset, then push s_len = 256 (DATA_BITS = 512) and 4 beats D0..D3 -> xfer pulses 4 times; m_axis emits D0..D3 with tlast only on D3.
- Push 64 beats with no length, m_axis_tready = 1 -> s_axis_tready falls after beat 64; xfer count = 64; m_axis_tvalid stays 0.
- Then push s_len = 4096 -> all 64 beats drain, tlast on beat 64, s_axis_tready returns to 1.
- Lengths 128, 0, 64 queued with 3 beats of data -> 2 beats with tlast on beat 2, then 1 beat with tlast; the zero-length entry is consumed silently.
- Random m_axis_tready backpressure (50%) over 1000 beats across 2-beat and 8-beat requests -> no beat lost or duplicated; tdata stable while stalled; tlast positions exact.
- Assert aresetn low mid-request (2 of 8 beats drained) -> next cycle tvalid = 0 and s_axis_tready = 1; stats = 0 with WR_QUEUE_STATS_EN; a new 1-beat request completes normally.
- With WR_QUEUE_STATS_EN: after 10 beats in and 3 requests done -> stat_beats_in = 10, stat_reqs_done = 3. Without the macro -> both read 0.
